// File: rtl/lenet_hw_prod_accum_if.sv
// Stream bundle for lenet_hw_prod_accum: product beats in, requantized group sums out.
interface lenet_hw_prod_accum_if #(
  parameter int unsigned PROD_W = 93,
  parameter int unsigned OUT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic              busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/lenet_hw_prod_accum.sv
// Saturating dot-product accumulator with shift requantization and output clamp.
// Define LENET_HW_PROD_ACCUM_ROUND_EN for round-half-up; default build truncates.
module lenet_hw_prod_accum #(
  parameter int unsigned PROD_W = 93,
  parameter int unsigned ACC_W  = 100,
  parameter int unsigned SHIFT  = 44,
  parameter int unsigned OUT_W  = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  lenet_hw_prod_accum_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_sat;
  logic               r_busy;

  logic               w_accept;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_ovf_next;
  logic [ACC_W:0]     w_rq;
  logic [ACC_W:0]     w_r;
  logic               w_clamp;
  logic [OUT_W-1:0]   w_q;

  assign w_accept = bus.in_valid & r_in_ready;

  // A beat taken in IDLE starts a fresh group regardless of leftover state.
  assign w_base     = (r_state == IDLE) ? '0 : r_acc;
  assign w_sum      = {1'b0, w_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_data};
  assign w_acc_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_ovf_next = ((r_state == IDLE) ? 1'b0 : r_ovf) | w_sum[ACC_W];

`ifdef LENET_HW_PROD_ACCUM_ROUND_EN
  localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  assign w_rq = {1'b0, w_acc_next} + RND;
`else
  assign w_rq = {1'b0, w_acc_next};
`endif

  // Requantize from the post-beat sum so the result is ready one cycle after the last accept.
  assign w_r     = w_rq >> SHIFT;
  assign w_clamp = w_ovf_next | (|(w_r >> OUT_W));
  assign w_q     = w_clamp ? '1 : w_r[OUT_W-1:0];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc  <= w_acc_next;
            r_ovf  <= w_ovf_next;
            r_busy <= 1'b1;
            if (bus.in_last) begin
              r_state     <= EMIT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_q;
              r_out_sat   <= w_clamp;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_lenet_hw_prod_accum.sv
// Bench for lenet_hw_prod_accum: directed vector table, reset corner cases, random groups vs model.
module tb_lenet_hw_prod_accum;

  localparam int unsigned PROD_W = 93;
  localparam int unsigned ACC_W  = 100;
  localparam int unsigned SHIFT  = 44;
  localparam int unsigned OUT_W  = 32;
`ifdef LENET_HW_PROD_ACCUM_ROUND_EN
  localparam bit RND_ON = 1'b1;
`else
  localparam bit RND_ON = 1'b0;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  lenet_hw_prod_accum_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

  lenet_hw_prod_accum #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  typedef struct {
    int unsigned       nbeats;
    logic [PROD_W-1:0] val;
    int unsigned       bp;
    logic [OUT_W-1:0]  exp_d;
    logic              exp_s;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [PROD_W-1:0] beats_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PROD_W-1:0] rand93();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[PROD_W-1:0];
  endfunction

  // Reference: clamped sum of the group, then shift (optionally rounded) and clamp to OUT_W.
  task automatic model(output logic [OUT_W-1:0] d, output logic s);
    logic [127:0] acc, lim, r;
    logic         ovf;
    lim = (128'd1 << ACC_W) - 128'd1;
    acc = '0;
    ovf = 1'b0;
    foreach (beats_q[i]) begin
      acc = acc + {35'd0, beats_q[i]};
      if (acc > lim) begin
        acc = lim;
        ovf = 1'b1;
      end
    end
    r = (acc + (RND_ON ? (128'd1 << (SHIFT - 1)) : 128'd0)) >> SHIFT;
    s = ovf || (r > 128'hFFFF_FFFF);
    d = s ? 32'hFFFF_FFFF : r[OUT_W-1:0];
  endtask

  // Drives beats_q as one group, then holds the result for bp cycles before taking it.
  task automatic run_group(input string name, input int unsigned bp,
                           input logic [OUT_W-1:0] exp_d, input logic exp_s);
    int unsigned n;
    int unsigned cnt;
    n = beats_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beats_q[i];
      bus.in_last  = (i == n - 1);
      cnt = 0;
      while (!bus.in_ready && cnt < 50) begin
        @(posedge ap_clk); #1;
        cnt++;
      end
      if (!bus.in_ready) begin
        check({name, " in_ready timeout"}, 128'd0, 128'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge ap_clk); #1;
      if (i != n - 1 && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = rand93();
        bus.in_last  = 1'($urandom);
        repeat ($urandom_range(1, 3)) begin
          @(posedge ap_clk); #1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check({name, " out_valid latency"}, 128'(bus.out_valid), 128'd1);
    check({name, " out_data"}, 128'(bus.out_data), 128'(exp_d));
    check({name, " out_sat"}, 128'(bus.out_sat), 128'(exp_s));
    check({name, " busy in emit"}, 128'(bus.busy), 128'd1);
    check({name, " in_ready in emit"}, 128'(bus.in_ready), 128'd0);
    for (int unsigned k = 0; k < bp; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand93();
      bus.in_last  = 1'($urandom);
      @(posedge ap_clk); #1;
      check({name, " bp out_valid"}, 128'(bus.out_valid), 128'd1);
      check({name, " bp out_data"}, 128'(bus.out_data), 128'(exp_d));
      check({name, " bp in_ready"}, 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus.out_ready = 1'b0;
    check({name, " out_valid drop"}, 128'(bus.out_valid), 128'd0);
    check({name, " busy idle"}, 128'(bus.busy), 128'd0);
    check({name, " in_ready idle"}, 128'(bus.in_ready), 128'd1);
  endtask

  vec_t vecs[8];

  initial begin
    logic [PROD_W-1:0] ones;
    logic [OUT_W-1:0]  md;
    logic              ms;
    ones = '1;
    vecs[0] = '{nbeats: 3,   val: 93'd3 << 43, bp: 0, exp_d: RND_ON ? 32'd5 : 32'd4, exp_s: 1'b0};
    vecs[1] = '{nbeats: 1,   val: 93'd1 << 44, bp: 0, exp_d: 32'd1, exp_s: 1'b0};
    vecs[2] = '{nbeats: 1,   val: 93'd7 << 44, bp: 5, exp_d: 32'd7, exp_s: 1'b0};
    vecs[3] = '{nbeats: 2,   val: 93'd1 << 75, bp: 0, exp_d: 32'hFFFF_FFFF, exp_s: 1'b1};
    vecs[4] = '{nbeats: 129, val: ones,        bp: 0, exp_d: 32'hFFFF_FFFF, exp_s: 1'b1};
    vecs[5] = '{nbeats: 1,   val: 93'd1 << 45, bp: 0, exp_d: 32'd2, exp_s: 1'b0};
    vecs[6] = '{nbeats: 1,   val: (93'd1 << 44) - 93'd1, bp: 0, exp_d: RND_ON ? 32'd1 : 32'd0, exp_s: 1'b0};
    vecs[7] = '{nbeats: 2,   val: 93'd3 << 42, bp: 2, exp_d: RND_ON ? 32'd2 : 32'd1, exp_s: 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge ap_clk);
    #1;
    check("reset in_ready", 128'(bus.in_ready), 128'd0);
    check("reset out_valid", 128'(bus.out_valid), 128'd0);
    check("reset out_data", 128'(bus.out_data), 128'd0);
    check("reset out_sat", 128'(bus.out_sat), 128'd0);
    check("reset busy", 128'(bus.busy), 128'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check("post-reset in_ready", 128'(bus.in_ready), 128'd1);

    for (int unsigned v = 0; v < 8; v++) begin
      beats_q.delete();
      for (int unsigned b = 0; b < vecs[v].nbeats; b++) beats_q.push_back(vecs[v].val);
      run_group($sformatf("vec%0d", v), vecs[v].bp, vecs[v].exp_d, vecs[v].exp_s);
    end

    // Reset after 2 of 4 beats: partial sum is discarded, no result appears.
    bus.in_valid = 1'b1;
    bus.in_data  = 93'd1 << 44;
    bus.in_last  = 1'b0;
    repeat (2) begin
      @(posedge ap_clk); #1;
    end
    bus.in_valid = 1'b0;
    ap_rst = 1'b1;
    #1;
    check("midrst in_ready", 128'(bus.in_ready), 128'd0);
    check("midrst busy", 128'(bus.busy), 128'd0);
    check("midrst out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst out_data", 128'(bus.out_data), 128'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check("midrst release out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst release in_ready", 128'(bus.in_ready), 128'd1);
    beats_q.delete();
    beats_q.push_back(93'd1 << 45);
    run_group("midrst newgroup", 0, 32'd2, 1'b0);

    // Reset while a result is pending drops it.
    beats_q.delete();
    beats_q.push_back(93'd9 << 44);
    bus.in_valid = 1'b1;
    bus.in_data  = beats_q[0];
    bus.in_last  = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("emitrst pending", 128'(bus.out_valid), 128'd1);
    ap_rst = 1'b1;
    #1;
    check("emitrst out_valid", 128'(bus.out_valid), 128'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check("emitrst release out_valid", 128'(bus.out_valid), 128'd0);

    for (int unsigned g = 0; g < 40; g++) begin
      int unsigned n;
      int unsigned sh;
      n = $urandom_range(1, 6);
      sh = $urandom_range(0, 92);
      beats_q.delete();
      for (int unsigned b = 0; b < n; b++) beats_q.push_back(rand93() >> sh);
      model(md, ms);
      run_group($sformatf("rand%0d", g), $urandom_range(0, 3), md, ms);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
